// File: rtl/flght_pkg.sv
// ---------------------------------------------------------------------------
// flght_pkg
// Shared definitions for the flight-controller command UART front end.
//   frame_state_t : command frame assembly states
//   FRAME_BYTES   : bytes per command frame (opcode, data high, data low)
//   UART_BITS     : bits per 8N1 character (start + 8 data + stop)
//   POS_ACK       : positive acknowledge response byte
//   join_data()   : packs the two data bytes into the 16-bit data word
// ---------------------------------------------------------------------------
package flght_pkg;

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        WAIT_HI  = 2'd1,
        WAIT_LO  = 2'd2
    } frame_state_t;

    localparam int FRAME_BYTES = 32'd3;
    localparam int UART_BITS   = 32'd10;

    localparam logic [7:0] POS_ACK = 8'hA5;

    function automatic logic [15:0] join_data(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/cmd_uart_wrapper_if.sv
// ---------------------------------------------------------------------------
// cmd_uart_wrapper_if
// Bundles the UART pins and the command-configurator handshake.
//   RX/TX          : serial lines (8N1, LSB first, idle high)
//   cmd_rdy        : complete frame held on cmd/data (sticky)
//   cmd, data      : opcode and {data high, data low}
//   clr_cmd_rdy    : consumer acknowledges the frame
//   send_resp/resp : one-cycle request to transmit resp
//   tx_busy        : transmitter shifting
//   resp_sent      : one-cycle pulse at end of the stop bit
// Modport slave is the wrapper side, master is the board/consumer side.
// ---------------------------------------------------------------------------
interface cmd_uart_wrapper_if;

    logic        RX;
    logic        TX;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tx_busy;
    logic        resp_sent;

    modport slave (
        input  RX, clr_cmd_rdy, send_resp, resp,
        output TX, cmd_rdy, cmd, data, tx_busy, resp_sent
    );

    modport master (
        output RX, clr_cmd_rdy, send_resp, resp,
        input  TX, cmd_rdy, cmd, data, tx_busy, resp_sent
    );

endinterface

// File: rtl/cmd_uart_wrapper_trx.sv
// ---------------------------------------------------------------------------
// uart_trx
// Byte-level 8N1 UART: RX synchroniser + mid-bit sampler and TX shifter.
// RX and TX run independently.
//   clk, rst   : clock, asynchronous active-high reset
//   i_rx       : raw serial input (asynchronous to clk)
//   o_tx       : serial output, idles high
//   rx_rdy     : one-cycle pulse, rx_data holds a byte with a valid stop bit
//   rx_data    : received byte
//   trmt       : request to transmit tx_data (ignored while busy)
//   tx_data    : byte to transmit, sampled with trmt
//   tx_done    : one-cycle pulse when the stop bit completes
//   o_tx_busy  : transmitter shifting
// ---------------------------------------------------------------------------
module uart_trx
    import flght_pkg::*;
#(
    parameter int BAUD_DIV = 32'd2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       o_tx_busy
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BAUD_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 32'd1);
    // Start bit is re-checked half a bit after the detected falling edge.
    localparam logic [BW-1:0] BAUD_MID  = BW'(BAUD_DIV / 32'd2 - 32'd1);
    localparam logic [3:0]    TX_LAST_BIT = 4'(UART_BITS - 32'd1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    rx_state_t     r_rx_state;
    logic [BW-1:0] r_rx_baud;
    logic [3:0]    r_rx_bits;
    logic [7:0]    r_rx_shift;
    logic          r_rx_rdy;
    logic [7:0]    r_rx_data;

    logic          r_tx;
    logic          r_tx_busy;
    logic          r_tx_done;
    logic [9:0]    r_tx_shift;
    logic [BW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bits;

    logic          w_rx_fall;
    logic          w_rx_baud_last;

    assign w_rx_fall      = r_rx_prev & ~r_rx_sync;
    assign w_rx_baud_last = (r_rx_baud == BAUD_LAST);

    // Two-flop synchroniser on RX plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // RX sampler: start validation, 8 LSB-first data bits, stop-bit check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_baud  <= BAUD_ZERO;
            r_rx_bits  <= 4'd0;
            r_rx_shift <= 8'h00;
            r_rx_rdy   <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            r_rx_rdy <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_baud <= BAUD_ZERO;
                    r_rx_bits <= 4'd0;
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                    end else begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (r_rx_baud == BAUD_MID) begin
                        r_rx_baud <= BAUD_ZERO;
                        // Line back high at mid-start: treat as a glitch.
                        if (r_rx_sync) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud + BAUD_ONE;
                    end
                end
                RX_DATA: begin
                    if (w_rx_baud_last) begin
                        r_rx_baud  <= BAUD_ZERO;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bits  <= r_rx_bits + 4'd1;
                        if (r_rx_bits == 4'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud + BAUD_ONE;
                    end
                end
                RX_STOP: begin
                    if (w_rx_baud_last) begin
                        r_rx_baud  <= BAUD_ZERO;
                        r_rx_state <= RX_IDLE;
                        // A low stop bit is a framing error: drop the byte.
                        if (r_rx_sync) begin
                            r_rx_rdy  <= 1'b1;
                            r_rx_data <= r_rx_shift;
                        end else begin
                            r_rx_rdy  <= 1'b0;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud + BAUD_ONE;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // TX shifter: {stop, data, start} shifted out LSB first, BAUD_DIV cycles per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_shift <= 10'h3FF;
            r_tx_baud  <= BAUD_ZERO;
            r_tx_bits  <= 4'd0;
        end else begin
            r_tx_done <= 1'b0;
            if (!r_tx_busy) begin
                if (trmt) begin
                    r_tx_shift <= {1'b1, tx_data, 1'b0};
                    r_tx       <= 1'b0;
                    r_tx_busy  <= 1'b1;
                    r_tx_baud  <= BAUD_ZERO;
                    r_tx_bits  <= 4'd0;
                end else begin
                    r_tx <= 1'b1;
                end
            end else if (r_tx_baud == BAUD_LAST) begin
                r_tx_baud <= BAUD_ZERO;
                if (r_tx_bits == TX_LAST_BIT) begin
                    r_tx_busy <= 1'b0;
                    r_tx_done <= 1'b1;
                    r_tx      <= 1'b1;
                end else begin
                    r_tx_bits  <= r_tx_bits + 4'd1;
                    r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                    r_tx       <= r_tx_shift[1];
                end
            end else begin
                r_tx_baud <= r_tx_baud + BAUD_ONE;
            end
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_busy = r_tx_busy;
    assign tx_done   = r_tx_done;
    assign rx_rdy    = r_rx_rdy;
    assign rx_data   = r_rx_data;

endmodule

// File: rtl/cmd_uart_wrapper.sv
// ---------------------------------------------------------------------------
// cmd_uart_wrapper
// Serial front end of the command path: assembles 3-byte frames
// (opcode, data high, data low) from RX and presents them with a sticky
// cmd_rdy; transmits 1-byte responses on TX.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : cmd_uart_wrapper_if.slave (RX, TX, cmd_rdy, cmd, data,
//          clr_cmd_rdy, send_resp, resp, tx_busy, resp_sent)
// Optional feature macro: FRAME_TIMEOUT_EN -- abandons a partial frame
// after TIMEOUT_CYC idle cycles in WAIT_HI/WAIT_LO.
// ---------------------------------------------------------------------------
module cmd_uart_wrapper
    import flght_pkg::*;
#(
    parameter int BAUD_DIV    = 32'd2604,
    parameter int TIMEOUT_CYC = 32'd1048576
) (
    input  logic                clk,
    input  logic                rst,
    cmd_uart_wrapper_if.slave   bus
);

    logic         w_rx_rdy;
    logic [7:0]   w_rx_data;
    logic         w_tx;
    logic         w_tx_busy;
    logic         w_tx_done;
    logic         w_first_byte;
    logic         w_frame_done;
    logic         w_timeout;

    frame_state_t r_state;
    logic [7:0]   r_cmd_hold;
    logic [7:0]   r_hi_hold;
    logic [7:0]   r_cmd;
    logic [15:0]  r_data;
    logic         r_cmd_rdy;

    uart_trx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_trx (
        .clk       (clk),
        .rst       (rst),
        .i_rx      (bus.RX),
        .o_tx      (w_tx),
        .rx_rdy    (w_rx_rdy),
        .rx_data   (w_rx_data),
        .trmt      (bus.send_resp),
        .tx_data   (bus.resp),
        .tx_done   (w_tx_done),
        .o_tx_busy (w_tx_busy)
    );

    assign w_first_byte = w_rx_rdy && (r_state == WAIT_CMD);
    assign w_frame_done = w_rx_rdy && (r_state == WAIT_LO);

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 32'd1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0] TO_ONE   = {{(TW-1){1'b0}}, 1'b1};

    logic [TW-1:0] r_to_cnt;

    // Inter-byte timer: restarts on every byte, only runs mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= TO_ZERO;
        end else if (w_rx_rdy || (r_state == WAIT_CMD) || w_timeout) begin
            r_to_cnt <= TO_ZERO;
        end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
        end
    end

    assign w_timeout = (r_to_cnt == TO_LIMIT);
`else
    // Without the timer a partial frame simply waits for more bytes.
    assign w_timeout = 1'b0;
`endif

    // Frame FSM with holding registers; presented cmd/data move only when a frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= WAIT_CMD;
            r_cmd_hold <= 8'h00;
            r_hi_hold  <= 8'h00;
            r_cmd      <= 8'h00;
            r_data     <= 16'h0000;
            r_cmd_rdy  <= 1'b0;
        end else begin
            // Completing a frame beats a simultaneous clear request.
            if (w_frame_done) begin
                r_cmd_rdy <= 1'b1;
            end else if (w_first_byte || bus.clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end else begin
                r_cmd_rdy <= r_cmd_rdy;
            end

            case (r_state)
                WAIT_CMD: begin
                    if (w_rx_rdy) begin
                        r_cmd_hold <= w_rx_data;
                        r_state    <= WAIT_HI;
                    end else begin
                        r_state    <= WAIT_CMD;
                    end
                end
                WAIT_HI: begin
                    if (w_rx_rdy) begin
                        r_hi_hold <= w_rx_data;
                        r_state   <= WAIT_LO;
                    end else if (w_timeout) begin
                        r_state   <= WAIT_CMD;
                    end else begin
                        r_state   <= WAIT_HI;
                    end
                end
                WAIT_LO: begin
                    if (w_rx_rdy) begin
                        r_cmd   <= r_cmd_hold;
                        r_data  <= join_data(r_hi_hold, w_rx_data);
                        r_state <= WAIT_CMD;
                    end else if (w_timeout) begin
                        r_state <= WAIT_CMD;
                    end else begin
                        r_state <= WAIT_LO;
                    end
                end
                default: begin
                    r_state <= WAIT_CMD;
                end
            endcase
        end
    end

    assign bus.TX        = w_tx;
    assign bus.tx_busy   = w_tx_busy;
    assign bus.resp_sent = w_tx_done;
    assign bus.cmd_rdy   = r_cmd_rdy;
    assign bus.cmd       = r_cmd;
    assign bus.data      = r_data;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// ---------------------------------------------------------------------------
// tb_cmd_uart_wrapper
// Directed, table-driven bench for cmd_uart_wrapper with a short baud
// divisor. Frames from a vector table plus hand-written sequences for
// clear/set priority, framing errors, TX serialisation, reset and the
// optional FRAME_TIMEOUT_EN behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmd_uart_wrapper;
    import flght_pkg::*;

    localparam int B  = 16;
    localparam int TO = 400;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    cmd_uart_wrapper_if u_if();

    cmd_uart_wrapper #(
        .BAUD_DIV    (B),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 character starting at a negedge; ends on a negedge after the byte settles.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frm;
        frm = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            u_if.RX = frm[i];
            repeat (B) @(negedge clk);
        end
        u_if.RX = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    function automatic logic tx_exp(input logic [7:0] v, input int k);
        if (k == 0) return 1'b0;
        else if (k == 9) return 1'b1;
        else return v[k-1];
    endfunction

    initial begin
        logic [7:0]  prev_cmd;
        logic [15:0] prev_data;
        int          hi_cnt;
        int          pulses;
        logic [7:0]  tv;

        n_checks = 0;
        n_fail   = 0;
        u_if.RX          = 1'b1;
        u_if.clr_cmd_rdy = 1'b0;
        u_if.send_resp   = 1'b0;
        u_if.resp        = 8'h00;
        rst = 1'b1;

        vecs[0] = '{8'h02, 8'h12, 8'h34, 8'h02, 16'h1234};
        vecs[1] = '{8'h03, 8'h00, 8'h10, 8'h03, 16'h0010};
        vecs[2] = '{8'h04, 8'h00, 8'h20, 8'h04, 16'h0020};
        vecs[3] = '{8'h7F, 8'h80, 8'h01, 8'h7F, 16'h8001};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_tx",        {31'd0, u_if.TX},        32'd1);
        check("rst_cmd_rdy",   {31'd0, u_if.cmd_rdy},   32'd0);
        check("rst_cmd",       {24'd0, u_if.cmd},       32'h00);
        check("rst_data",      {16'd0, u_if.data},      32'h0000);
        check("rst_tx_busy",   {31'd0, u_if.tx_busy},   32'd0);
        check("rst_resp_sent", {31'd0, u_if.resp_sent}, 32'd0);

        // Table-driven frames; each frame is left uncleared so byte 0 of the next drops cmd_rdy
        prev_cmd  = 8'h00;
        prev_data = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].b0, 1'b1);
            check("b0_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
            check("b0_cmd_hold", {24'd0, u_if.cmd}, {24'd0, prev_cmd});
            send_byte(vecs[i].b1, 1'b1);
            check("b1_data_hold", {16'd0, u_if.data}, {16'd0, prev_data});
            check("b1_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
            send_byte(vecs[i].b2, 1'b1);
            check("frame_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd1);
            check("frame_cmd", {24'd0, u_if.cmd}, {24'd0, vecs[i].exp_cmd});
            check("frame_data", {16'd0, u_if.data}, {16'd0, vecs[i].exp_data});
            prev_cmd  = vecs[i].exp_cmd;
            prev_data = vecs[i].exp_data;
        end

        // clr_cmd_rdy pulse clears the flag, leaves cmd/data alone
        u_if.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        u_if.clr_cmd_rdy = 1'b0;
        check("clr_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
        check("clr_cmd", {24'd0, u_if.cmd}, 32'h7F);
        check("clr_data", {16'd0, u_if.data}, 32'h8001);

        // clr held through the last byte: set wins for exactly one cycle
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        u_if.clr_cmd_rdy = 1'b1;
        hi_cnt = 0;
        fork
            send_byte(8'hEF, 1'b1);
            begin
                for (int k = 0; k < 10 * B + 6; k++) begin
                    @(negedge clk);
                    if (u_if.cmd_rdy) hi_cnt++;
                end
            end
        join
        u_if.clr_cmd_rdy = 1'b0;
        check("set_wins_cycles", hi_cnt, 32'd1);
        check("set_wins_cmd", {24'd0, u_if.cmd}, 32'hAB);
        check("set_wins_data", {16'd0, u_if.data}, 32'hCDEF);

        // Framing error inside a frame: bad byte is ignored
        send_byte(8'h05, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h77, 1'b0);
        check("ferr_cmd_rdy_mid", {31'd0, u_if.cmd_rdy}, 32'd0);
        send_byte(8'hFF, 1'b1);
        check("ferr_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd1);
        check("ferr_cmd", {24'd0, u_if.cmd}, 32'h05);
        check("ferr_data", {16'd0, u_if.data}, 32'h01FF);
        send_byte(8'h00, 1'b1);
        check("ferr_next_frame", {31'd0, u_if.cmd_rdy}, 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("ferr_follow_cmd", {24'd0, u_if.cmd}, 32'h00);
        check("ferr_follow_data", {16'd0, u_if.data}, 32'h1122);

        // TX of POS_ACK, ignored mid-character request, back-to-back accept on resp_sent
        tv = POS_ACK;
        pulses = 0;
        u_if.send_resp = 1'b1;
        u_if.resp      = tv;
        @(negedge clk);
        u_if.send_resp = 1'b0;
        for (int n = 0; n <= 10 * B + 1; n++) begin
            if (n < 10 * B && (n % B) == B / 2)
                check("tx_bit", {31'd0, u_if.TX}, {31'd0, tx_exp(tv, n / B)});
            if (u_if.resp_sent) pulses++;
            if (n == 0) check("tx_busy_rise", {31'd0, u_if.tx_busy}, 32'd1);
            if (n == 3 * B) begin
                u_if.send_resp = 1'b1;
                u_if.resp      = 8'h00;
            end
            if (n == 3 * B + 1) u_if.send_resp = 1'b0;
            if (n == 10 * B) begin
                check("resp_sent_time", {31'd0, u_if.resp_sent}, 32'd1);
                check("tx_busy_fall", {31'd0, u_if.tx_busy}, 32'd0);
                u_if.send_resp = 1'b1;
                u_if.resp      = 8'h3C;
            end
            if (n == 10 * B + 1) begin
                u_if.send_resp = 1'b0;
                check("b2b_busy", {31'd0, u_if.tx_busy}, 32'd1);
                check("b2b_start", {31'd0, u_if.TX}, 32'd0);
            end
            @(negedge clk);
        end
        check("resp_sent_pulses", pulses, 32'd1);
        repeat (10 * B + 4) @(negedge clk);
        check("b2b_done_busy", {31'd0, u_if.tx_busy}, 32'd0);
        check("b2b_done_tx", {31'd0, u_if.TX}, 32'd1);

        // Reset after byte 1 of a frame
        send_byte(8'h11, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
        check("rst_mid_data", {16'd0, u_if.data}, 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-TX during a low data bit
        u_if.send_resp = 1'b1;
        u_if.resp      = 8'hA5;
        @(negedge clk);
        u_if.send_resp = 1'b0;
        repeat (2 * B + B / 2) @(negedge clk);
        check("pre_rst_tx_low", {31'd0, u_if.TX}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_tx_high", {31'd0, u_if.TX}, 32'd1);
        check("rst_tx_busy", {31'd0, u_if.tx_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_byte(8'h06, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("post_rst_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd1);
        check("post_rst_cmd", {24'd0, u_if.cmd}, 32'h06);
        check("post_rst_data", {16'd0, u_if.data}, 32'h0000);

        // Partial frame followed by a long idle gap
        send_byte(8'h02, 1'b1);
        repeat (TO + 1) @(negedge clk);
        send_byte(8'h03, 1'b1);
        send_byte(8'hAA, 1'b1);
`ifdef FRAME_TIMEOUT_EN
        send_byte(8'hBB, 1'b1);
        check("to_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd1);
        check("to_cmd", {24'd0, u_if.cmd}, 32'h03);
        check("to_data", {16'd0, u_if.data}, 32'hAABB);
`else
        check("noto_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd1);
        check("noto_cmd", {24'd0, u_if.cmd}, 32'h02);
        check("noto_data", {16'd0, u_if.data}, 32'h03AA);
        send_byte(8'hBB, 1'b1);
        check("noto_next_frame", {31'd0, u_if.cmd_rdy}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
